// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared 64-bit RAM bus.
// Each grant runs one single-beat access: IDLE -> ACCESS (RAM_WAIT cycles) -> ACK -> IDLE.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int RAM_WAIT = 2,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic [63:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic [63:0] m1_rdata,
    output logic        m1_ack,
    output logic [1:0]  owner,
    output logic [63:0] bus_addr,
    inout  wire  [63:0] bus_data,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_oe
);

    generate
        if (RAM_WAIT < 1) begin : g_bad_wait
            $error("mem_bus_arbiter: RAM_WAIT must be at least 1");
        end
        if ((64'd1 << CNT_W) <= RAM_WAIT) begin : g_bad_cnt
            $error("mem_bus_arbiter: CNT_W too narrow for RAM_WAIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_WAIT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        owner_reg, owner_next;
    logic              last_reg, last_next;     // 0 = master 0 served last, 1 = master 1
    logic [63:0]       addr_reg, addr_next;
    logic [63:0]       wdata_reg, wdata_next;
    logic              we_reg, we_next;
    logic [63:0]       rdata0_reg, rdata0_next;
    logic [63:0]       rdata1_reg, rdata1_next;
    logic              ack0_reg, ack0_next;
    logic              ack1_reg, ack1_next;
    logic              cs_reg, cs_next;
    logic              wen_reg, wen_next;
    logic              oe_reg, oe_next;
    logic              grant_m1;

    // Master 1 wins when alone, or on a tie when master 0 was served last.
    assign grant_m1 = m1_req && (!m0_req || !last_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            owner_reg  <= 2'b00;
            last_reg   <= 1'b1;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            cs_reg     <= 1'b0;
            wen_reg    <= 1'b0;
            oe_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            we_reg     <= we_next;
            rdata0_reg <= rdata0_next;
            rdata1_reg <= rdata1_next;
            ack0_reg   <= ack0_next;
            ack1_reg   <= ack1_next;
            cs_reg     <= cs_next;
            wen_reg    <= wen_next;
            oe_reg     <= oe_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        we_next     = we_reg;
        rdata0_next = rdata0_reg;
        rdata1_next = rdata1_reg;
        ack0_next   = 1'b0;
        ack1_next   = 1'b0;
        cs_next     = cs_reg;
        wen_next    = wen_reg;
        oe_next     = oe_reg;

        case (state_reg)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    addr_next  = grant_m1 ? m1_addr  : m0_addr;
                    wdata_next = grant_m1 ? m1_wdata : m0_wdata;
                    we_next    = grant_m1 ? m1_we    : m0_we;
                    owner_next = grant_m1 ? 2'b10    : 2'b01;
                    cnt_next   = CNT_LOAD;
                    cs_next    = 1'b1;
                    wen_next   = grant_m1 ? m1_we  : m0_we;
                    oe_next    = grant_m1 ? !m1_we : !m0_we;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_reg == '0) begin
                    // Last strobe cycle: RAM read data is valid on this edge.
                    if (!we_reg && owner_reg[0]) rdata0_next = bus_data;
                    if (!we_reg && owner_reg[1]) rdata1_next = bus_data;
                    ack0_next  = owner_reg[0];
                    ack1_next  = owner_reg[1];
                    cs_next    = 1'b0;
                    wen_next   = 1'b0;
                    oe_next    = 1'b0;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_ACK: begin
                last_next  = owner_reg[1];
                owner_next = 2'b00;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tri-state enables decode straight from state so an async reset releases the bus at once.
    assign bus_addr = (state_reg == ST_ACCESS) ? addr_reg : 64'bz;
    assign bus_data = (state_reg == ST_ACCESS && we_reg) ? wdata_reg : 64'bz;

    assign owner    = owner_reg;
    assign m0_rdata = rdata0_reg;
    assign m1_rdata = rdata1_reg;
    assign m0_ack   = ack0_reg;
    assign m1_ack   = ack1_reg;
    assign ram_cs   = cs_reg;
    assign ram_we   = wen_reg;
    assign ram_oe   = oe_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: RAM_WAIT=2 instance with a small RAM model,
// plus a RAM_WAIT=1 instance for the single-cycle strobe timing.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam logic [63:0] KEEP     = 64'hA5A5_5A5A_A5A5_5A5A;
    localparam logic [63:0] W1_CONST = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V_10     = 64'hDEAD_BEEF_0000_0013;
    localparam logic [63:0] V_18     = 64'hCAFE_F00D_0000_0018;
    localparam logic [63:0] V_20     = 64'h4444_4444_0000_0020;
    localparam logic [63:0] WR_40    = 64'h1122_3344_5566_7788;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [63:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [1:0]  owner;
    logic [63:0] bus_addr;
    wire  [63:0] bus_data;
    logic        ram_cs, ram_we, ram_oe;

    logic        w1_m0_req;
    logic [63:0] w1_m0_rdata, w1_m1_rdata;
    logic        w1_m0_ack, w1_m1_ack;
    logic [1:0]  w1_owner;
    logic [63:0] w1_bus_addr;
    wire  [63:0] w1_bus_data;
    logic        w1_ram_cs, w1_ram_we, w1_ram_oe;

    logic [63:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(.RAM_WAIT(2), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .owner(owner), .bus_addr(bus_addr), .bus_data(bus_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    mem_bus_arbiter #(.RAM_WAIT(1), .CNT_W(4)) u_dut_w1 (
        .clk(clk), .reset(reset),
        .m0_req(w1_m0_req), .m0_we(1'b0), .m0_addr(64'h8), .m0_wdata(64'h0),
        .m0_rdata(w1_m0_rdata), .m0_ack(w1_m0_ack),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(64'h0), .m1_wdata(64'h0),
        .m1_rdata(w1_m1_rdata), .m1_ack(w1_m1_ack),
        .owner(w1_owner), .bus_addr(w1_bus_addr), .bus_data(w1_bus_data),
        .ram_cs(w1_ram_cs), .ram_we(w1_ram_we), .ram_oe(w1_ram_oe)
    );

    // RAM answers reads while oe is up; a keeper pattern shows up whenever the bus should be free.
    assign bus_data    = ram_oe ? mem[bus_addr[10:3]] : (ram_cs ? 64'bz : KEEP);
    assign w1_bus_data = w1_ram_oe ? W1_CONST : 64'bz;

    always @(posedge clk) begin
        if (!reset) begin
            mem[2] <= V_10;
            mem[3] <= V_18;
            mem[4] <= V_20;
        end else if (ram_cs && ram_we) begin
            mem[bus_addr[10:3]] <= bus_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_owner;
        int phase, round;

        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        w1_m0_req = 0;
        #2 reset = 1'b0;
        step; step;

        check_val("rst_owner", owner, 2'b00);
        check_val("rst_cs", ram_cs, 1'b0);
        check_val("rst_oe", ram_oe, 1'b0);
        check_val("rst_we", ram_we, 1'b0);
        check_val("rst_ack0", m0_ack, 1'b0);
        check_val("rst_rdata0", m0_rdata, 64'h0);
        check_val("rst_rdata1", m1_rdata, 64'h0);
        check_val("rst_bus_free", bus_data, KEEP);
        reset = 1'b1;
        step;

        // Master 0 read of 0x10
        m0_addr = 64'h10; m0_we = 0; m0_req = 1;
        step;
        check_val("rd_cs1", ram_cs, 1'b1);
        check_val("rd_oe1", ram_oe, 1'b1);
        check_val("rd_we1", ram_we, 1'b0);
        check_val("rd_addr1", bus_addr, 64'h10);
        check_val("rd_owner", owner, 2'b01);
        check_val("rd_noack", m0_ack, 1'b0);
        step;
        check_val("rd_cs2", ram_cs, 1'b1);
        check_val("rd_oe2", ram_oe, 1'b1);
        step;
        check_val("rd_ack", m0_ack, 1'b1);
        check_val("rd_ack1_idle", m1_ack, 1'b0);
        check_val("rd_cs_off", ram_cs, 1'b0);
        check_val("rd_oe_off", ram_oe, 1'b0);
        check_val("rd_rdata", m0_rdata, V_10);
        check_val("rd_bus_free", bus_data, KEEP);
        m0_req = 0;
        step;
        check_val("rd_ack_drop", m0_ack, 1'b0);
        check_val("rd_owner_idle", owner, 2'b00);

        // Master 1 write of 0x40
        m1_addr = 64'h40; m1_wdata = WR_40; m1_we = 1; m1_req = 1;
        step;
        check_val("wr_cs1", ram_cs, 1'b1);
        check_val("wr_we1", ram_we, 1'b1);
        check_val("wr_oe1", ram_oe, 1'b0);
        check_val("wr_data1", bus_data, WR_40);
        check_val("wr_addr1", bus_addr, 64'h40);
        check_val("wr_owner", owner, 2'b10);
        step;
        check_val("wr_data2", bus_data, WR_40);
        check_val("wr_we2", ram_we, 1'b1);
        step;
        check_val("wr_ack1", m1_ack, 1'b1);
        check_val("wr_ack0_idle", m0_ack, 1'b0);
        check_val("wr_we_off", ram_we, 1'b0);
        check_val("wr_rdata0_kept", m0_rdata, V_10);
        check_val("wr_rdata1_kept", m1_rdata, 64'h0);
        check_val("wr_bus_free", bus_data, KEEP);
        check_val("wr_ram_content", mem[8], WR_40);
        m1_req = 0;
        step;
        check_val("wr_owner_idle", owner, 2'b00);

        // Address change during ACCESS is ignored
        m0_addr = 64'h18; m0_we = 0; m0_req = 1;
        step;
        check_val("lat_addr1", bus_addr, 64'h18);
        m0_addr = 64'h20;
        step;
        check_val("lat_addr2", bus_addr, 64'h18);
        step;
        check_val("lat_ack", m0_ack, 1'b1);
        check_val("lat_rdata", m0_rdata, V_18);
        m0_req = 0;
        step;

        // Reset in the second ACCESS cycle, then both masters held
        m0_addr = 64'h10; m0_we = 0; m0_req = 1;
        step;
        check_val("ra_owner", owner, 2'b01);
        step;
        check_val("ra_cs_pre", ram_cs, 1'b1);
        reset = 1'b0;
        m1_addr = 64'h40; m1_we = 0; m1_req = 1;
        #1;
        check_val("ra_cs", ram_cs, 1'b0);
        check_val("ra_oe", ram_oe, 1'b0);
        check_val("ra_owner_clr", owner, 2'b00);
        check_val("ra_rdata_clr", m0_rdata, 64'h0);
        check_val("ra_bus_free", bus_data, KEEP);
        step;
        check_val("ra_noack", m0_ack, 1'b0);
        reset = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step;
            phase = (c - 1) % 4;
            round = (c - 1) / 4;
            exp_owner = (phase == 3) ? 2'b00 : ((round % 2 == 0) ? 2'b01 : 2'b10);
            check_val($sformatf("rr_owner_c%0d", c), owner, exp_owner);
            check_val($sformatf("rr_ack0_c%0d", c), m0_ack, (phase == 2 && round % 2 == 0));
            check_val($sformatf("rr_ack1_c%0d", c), m1_ack, (phase == 2 && round % 2 == 1));
        end
        m0_req = 0; m1_req = 0;
        check_val("rr_rdata0", m0_rdata, V_10);
        check_val("rr_rdata1", m1_rdata, WR_40);
        step;

        // RAM_WAIT=1 instance: one strobe cycle, ack next cycle, 3-cycle period
        w1_m0_req = 1;
        for (int c = 1; c <= 6; c++) begin
            step;
            check_val($sformatf("w1_cs_c%0d", c), w1_ram_cs, (c % 3 == 1));
            check_val($sformatf("w1_ack_c%0d", c), w1_m0_ack, (c % 3 == 2));
        end
        w1_m0_req = 0;
        check_val("w1_rdata", w1_m0_rdata, W1_CONST);
        check_val("w1_ack1_idle", w1_m1_ack, 1'b0);
        step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared 64-bit RAM bus: bus_addr, bus_data, ram_cs, ram_we and ram_oe.
- Master 0 is the CPU core. Master 1 is the program loader/DMA port.
- Each request is a single-beat read or write. The block grants the bus round-robin, holds RAM strobes for a fixed number of wait cycles, captures read data, and returns a one-cycle ack.
- It sits between the masters and the RAM; the RAM sees it as its only driver.

Parameters:
- RAM_WAIT, 2: cycles ram_cs plus ram_oe/ram_we are held per access. Must be ≥1; values <1 are a synthesis error.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > RAM_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  64  master 0 byte address
- m0_wdata  in  64  master 0 write data
- m0_rdata  out  64  master 0 read data, registered
- m0_ack  out  1  master 0 completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- owner  out  2  00 idle, 01 master 0, 10 master 1
- bus_addr  out  64  RAM address; high-Z when not in ACCESS
- bus_data  inout  64  RAM data; driven only in ACCESS with a write, else high-Z
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, owner=00, last=master 1 (so master 0 wins the first tie).
  - ram_cs/ram_we/ram_oe=0; m0_ack/m1_ack=0; m0_rdata/m1_rdata=0.
  - bus_addr and bus_data high-Z.
- FSM states: IDLE → ACCESS → ACK → IDLE. All outputs are registered except the tri-state enables, which decode from state and the latched we.
- IDLE:
  - Sample reqs at each edge.
  - Only one req high: grant that master.
  - Both high: grant the master ≠ last.
  - On grant: latch addr, wdata and we into internal registers; set owner; cnt=RAM_WAIT-1; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - ram_cs=1. ram_we=latched we, ram_oe=~latched we.
  - bus_addr=latched addr. For a write, bus_data=latched wdata.
  - cnt decrements each cycle. On the edge where cnt==0:
    - Read: capture bus_data into the owner's rdata register.
    - Go to ACK.
  - Duration is exactly RAM_WAIT cycles.
- ACK:
  - Strobes return to 0; bus released to high-Z.
  - The owner's ack=1 for exactly one cycle; last=owner; owner=00 on exit; go to IDLE.
- Latency: req sampled at edge N → ACCESS cycles N+1..N+RAM_WAIT → ack high in cycle N+RAM_WAIT+1 → IDLE again at N+RAM_WAIT+2.
- Throughput: back-to-back transactions cost RAM_WAIT+2 cycles each.
- Masters must drop req on the edge where they observe ack, or a new request is taken.
- Address and data are latched at grant. Master changes to addr/wdata/we during ACCESS are ignored.
- Req dropped before ack: the transaction still completes and ack still pulses.
- Simultaneous reqs at reset release: master 0 served first, then master 1, then alternating while both stay asserted.
- The non-owner's ack stays 0. Its rdata holds its old value.
- A write leaves the owner's rdata unchanged. rdata holds until the next read by that master.
- Reset during ACCESS: strobes drop immediately, no ack is issued, rdata is cleared, and the RAM write may be partial.
- cnt never wraps, since it is reloaded at every grant.

Test Plan:
- Master 0 read only, RAM_WAIT=2, m0_addr=0x10, RAM returns 0xDEADBEEF00000013:
  - ram_oe/ram_cs high 2 cycles, bus_addr=0x10.
  - m0_ack one cycle later; m0_rdata=0xDEADBEEF00000013; owner=01 during ACCESS.
- Master 1 write, m1_addr=0x40, m1_wdata=0x1122334455667788:
  - bus_data=0x1122334455667788 and ram_we=1 for 2 cycles; ram_oe=0; m1_ack pulse.
  - m0_rdata unchanged; bus_data high-Z afterwards.
- Both reqs held continuously from reset:
  - grant order m0, m1, m0, m1.
  - ack pulses every 4 cycles (RAM_WAIT=2), alternating masters.
- Master 0 changes m0_addr from 0x10 to 0x20 mid-ACCESS: bus_addr stays 0x10 for the whole access.
- reset asserted during the second ACCESS cycle:
  - ram_cs/ram_we/ram_oe=0 and bus high-Z the same cycle; no ack.
  - After release, master 0 wins the first tie.
- RAM_WAIT=1 build: single-cycle strobe; ack 2 cycles after the req sample edge; 3-cycle back-to-back period.
